// File: rtl/seg_pipe_addsub.sv
// Pipelined WIDTH-bit add/sub. The carry chain is cut into SEGS registered CHUNK-bit slices.
// Latency: SEGS cycles from acceptance to out_valid. One op per cycle while out_ready stays high.
// Backpressure: valid/ready on both sides. Stages collapse bubbles, and in_ready = adv[0] && !flush.
module seg_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int CHUNK = WIDTH / SEGS;

    // Stage j hands (SEGS-1-j)*CHUNK still-unused b_eff bits to stage j+1.
    // Those bits are packed back to back in b_chain.
    function automatic int boff(input int j);
        int o;
        o = 0;
        for (int i = 0; i < j; i++) o += (SEGS - 1 - i) * CHUNK;
        return o;
    endfunction

    localparam int BT  = boff(SEGS - 1);
    localparam int BTW = (BT > 0) ? BT : 1;

    logic [SEGS-1:0]            v_q, v_d, c_q, c_d;
    logic [SEGS-1:0][WIDTH-1:0] w_q, w_d;   // low slices hold sum, high slices still hold a
    logic                       ovf_q, ovf_d;
    logic [SEGS-1:0][WIDTH-1:0] nw;
    logic [SEGS-1:0]            nc, sv, ld, adv;
    logic                       ovf_n;
    logic [BTW-1:0]             b_chain;

    always_comb begin
        logic nxt;
        adv = '0;
        nxt = !v_q[SEGS-1] || out_ready;
        adv[SEGS-1] = nxt;
        for (int k = SEGS - 2; k >= 0; k--) begin
            nxt    = !v_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    assign in_ready = adv[0] && !flush;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        localparam int IW = (SEGS - k) * CHUNK;
        localparam logic [WIDTH-1:0] ONES = '1;
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - CHUNK)) << (k * CHUNK);
        logic [WIDTH-1:0] sw;
        logic [IW-1:0]    sb;
        logic             sc;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_head
            assign sw    = in_a;
            assign sb    = in_sub ? ~in_b : in_b;
            assign sc    = in_cin ^ in_sub;
            assign sv[k] = in_valid && in_ready;
        end else begin : g_body
            assign sw    = w_q[k-1];
            assign sb    = b_chain[boff(k-1) +: IW];
            assign sc    = c_q[k-1];
            assign sv[k] = v_q[k-1];
        end

        assign part  = {1'b0, sw[k*CHUNK +: CHUNK]} + {1'b0, sb[CHUNK-1:0]} + {{CHUNK{1'b0}}, sc};
        assign nw[k] = (sw & ~MASK) | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
        assign nc[k] = part[CHUNK];

        if (k < SEGS - 1) begin : g_carry
            localparam int OW = IW - CHUNK;
            logic [OW-1:0] b_q, b_d;

            always_comb begin
                b_d = b_q;
                if (ld[k]) b_d = sb[IW-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) b_q <= '0;
                else        b_q <= b_d;
            end

            assign b_chain[boff(k) +: OW] = b_q;
        end else begin : g_last
            // The top slice is resolved here, so sw[MSB] is still the original a[MSB].
            assign ovf_n = (sw[WIDTH-1] == sb[IW-1]) && (nw[k][WIDTH-1] != sw[WIDTH-1]);
        end
    end

    always_comb begin
        v_d   = v_q;
        w_d   = w_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        ld    = '0;
        for (int k = 0; k < SEGS; k++) begin
            ld[k] = adv[k] && sv[k] && !flush;
            if (flush)       v_d[k] = 1'b0;
            else if (adv[k]) v_d[k] = sv[k];
            // Data only loads with a real op, so out_* keep the last result across bubbles and flush.
            if (ld[k]) begin
                w_d[k] = nw[k];
                c_d[k] = nc[k];
            end
        end
        if (ld[SEGS-1]) ovf_d = ovf_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            w_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            w_q   <= w_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[SEGS-1];
    assign out_sum   = w_q[SEGS-1];
    assign out_cout  = c_q[SEGS-1];
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Bench for seg_pipe_addsub: vector table, stall/flush/reset sequences and a random burst.
// Expected results are queued on acceptance and compared when the DUT hands a result out.
module tb_seg_pipe_addsub;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         want;
    } vec_t;

    logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic         in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_cout, out_ovf;
    logic [W-1:0] out_sum;

    res_t sb[$];
    res_t e, held_v;
    logic held = 1'b0;
    int   n_checks = 0, n_pass = 0, n_pops = 0;

    seg_pipe_addsub #(.WIDTH(W), .SEGS(S)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        res_t r;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub ? ~cin : cin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input logic [W-1:0] s, input logic c, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.want.sum = s; v.want.cout = c; v.want.ovf = o;
        return v;
    endfunction

    function automatic res_t rs(input logic [W-1:0] s, input logic c, input logic o);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = o;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (held && out_valid) check("stable_while_stalled", {out_sum, out_cout, out_ovf}, held_v);
            held   = out_valid && !out_ready && !flush;
            held_v = {out_sum, out_cout, out_ovf};
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL stale_result: got sum %0h with nothing outstanding", out_sum);
                end else begin
                    e = sb.pop_front();
                    check("result", {out_sum, out_cout, out_ovf}, e);
                end
            end
            if (flush) sb.delete();
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge rst_n) begin
        sb.delete();
        held = 1'b0;
    end

    // Called just after a posedge; returns just after the edge that accepted the op.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input res_t want);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(want);
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 64 cycles");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_latency(input string name);
        int  gap;
        bit  seen;
        gap  = 0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
            gap++;
        end
        check(name, seen ? gap : 99, S - 1);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    int   pops0, seen_v;
    bit   done;

    initial begin
        tbl[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tbl[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        tbl[2] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        tbl[3] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tbl[4] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tbl[5] = mk(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        tbl[6] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tbl[7] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        tbl[8] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        tbl[9] = mk(16'h0FFF, 16'hF001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_cout", out_cout, 0);
        check("reset_out_ovf", out_ovf, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b1;
            drive_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].want);
            in_valid = 1'b0;
            wait_latency($sformatf("latency_vec%0d", i));
            @(negedge clk);
            check($sformatf("one_cycle_vec%0d", i), out_valid, 0);
            @(posedge clk);
            #1;
        end

        // Eight back-to-back ops with the consumer stalled over cycles 2..6.
        pops0 = n_pops;
        fork
            begin
                for (int i = 1; i <= 8; i++) drive_op(W'(i), W'(i), 1'b0, 1'b0, rs(W'(2 * i), 1'b0, 1'b0));
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 7; c++) begin
                    @(posedge clk);
                    #1 out_ready = (c < 2) || (c > 6);
                    if (c >= 4 && c <= 6) begin
                        @(negedge clk);
                        check("bp_in_ready_low", in_ready, 0);
                        check("bp_out_valid", out_valid, 1);
                        check("bp_out_sum_held", out_sum, 16'h0002);
                    end
                end
            end
        join
        drain("bp_drain");
        check("bp_all_delivered", n_pops - pops0, 8);

        // Flush with two ops in flight and a third offered in the same cycle.
        out_ready = 1'b1;
        drive_op(16'h0101, 16'h0202, 1'b0, 1'b0, rs(16'h0303, 1'b0, 1'b0));
        drive_op(16'h1111, 16'h1111, 1'b0, 1'b1, rs(16'h0000, 1'b1, 1'b0));
        in_a = 16'h4000; in_b = 16'h4000; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_keeps_sum", out_sum, 16'h0010);
        drive_op(16'h4000, 16'h4000, 1'b0, 1'b0, rs(16'h8000, 1'b0, 1'b1));
        in_valid = 1'b0;
        wait_latency("flush_next_latency");
        @(posedge clk);
        #1;

        // Asynchronous reset pulse between edges with three ops in flight.
        drive_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, rs(16'h1010, 1'b0, 1'b0));
        drive_op(16'h2222, 16'h1111, 1'b0, 1'b1, rs(16'h1111, 1'b1, 1'b0));
        drive_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, rs(16'hFFFF, 1'b0, 1'b0));
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_sum", out_sum, 0);
        check("arst_out_cout", out_cout, 0);
        check("arst_out_ovf", out_ovf, 0);
        #2 rst_n = 1'b1;
        #1 check("arst_in_ready", in_ready, 1);
        seen_v = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_v++;
        end
        check("arst_no_stale", seen_v, 0);
        @(posedge clk);
        #1;

        // Random mix of add/sub with random input gaps and consumer stalls.
        pops0 = n_pops;
        done  = 0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    logic [W-1:0] ra, rb;
                    logic         rc, rsub;
                    ra   = W'($urandom);
                    rb   = W'($urandom);
                    rc   = 1'($urandom_range(0, 1));
                    rsub = 1'($urandom_range(0, 1));
                    drive_op(ra, rb, rc, rsub, model(ra, rb, rc, rsub));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");
        check("rand_all_delivered", n_pops - pops0, 80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/seg_pipe_addsub.md
Name: seg_pipe_addsub

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow in.
- Splits the carry chain into SEGS registered segments. Each stage resolves one CHUNK = WIDTH/SEGS-bit slice and passes its carry to the next stage.
- Uses valid/ready handshakes on both sides, supports full backpressure, and sits between operand sources and a result consumer in the datapath.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be ≥ 2 and divisible by SEGS.
- SEGS, 4: number of pipeline stages (carry segments). 1 ≤ SEGS ≤ WIDTH. Latency = SEGS cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight operations.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept the bundle this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) or borrow-in (sub).
- in_sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  raw carry out of the MSB. For subtraction, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - Add: {cout, sum} = a + b + cin.
  - Sub: {cout, sum} = a + ~b + ~cin, which equals a − b − cin modulo 2^WIDTH.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = in_sub ? ~b : b.
  - Results must be bit-identical to a full-width combinational reference for all inputs.
- Pipeline:
  - Stage k (0..SEGS−1) computes slice [k*CHUNK +: CHUNK] using the carry registered by stage k−1. Stage 0 uses the effective cin.
  - Unprocessed upper slices of a and b_eff travel with the operation.
  - Completed lower sum slices travel with the operation.
  - The final stage registers drive out_* directly. No combinational path from in_* to out_*.
- Handshake:
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - Each stage has a valid bit v[k]. The last stage is the output register, so out_valid = v[SEGS−1].
  - adv[SEGS−1] = !v[SEGS−1] || out_ready.
  - adv[k] = !v[k] || adv[k+1] (bubble-collapsing).
  - in_ready = adv[0] && !flush. Because in_ready depends combinationally on out_ready, the path is permitted.
  - A stage captures its predecessor's data only when adv[k] is high. Otherwise it holds.
  - A stage whose predecessor is empty and whose own value leaves becomes empty.
  - Capacity is SEGS operations. Throughput is 1 op/cycle when out_ready stays high.
  - Latency: an op accepted at edge N has out_valid = 1 after edge N+SEGS−1, assuming no stalls.
  - Ordering is strictly FIFO. No op is dropped or duplicated.
  - out_* must remain stable while out_valid && !out_ready.
- Reset (rst_n low, asynchronous, including mid-operation):
  - All v[k] = 0, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0.
  - in_ready = 1 as soon as rst_n is high.
  - Data registers other than the out_* registers are don't-care.
- flush:
  - At the next edge, all v[k] = 0. out_sum, out_cout and out_ovf keep their last values but are not valid.
  - in_ready = 0 in the flush cycle, so no op is accepted.
  - flush overrides simultaneous in_valid and out_ready. A result already presented with out_ready high in the flush cycle counts as transferred.
- SEGS = 1 degenerates to a single-register add with 1-cycle latency.
- in_sub is captured per operation. Add and sub ops may interleave freely.

Test Plan:
- WIDTH=16, SEGS=4, add 0xFFFF + 0x0001, cin=0, out_ready=1 → after 4 edges: out_sum=0x0000, cout=1, ovf=0, out_valid for exactly 1 cycle.
- Add 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. Add 0x1234 + 0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Sub 0x0005 − 0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Issue 8 back-to-back ops (a=i, b=i, i=1..8) with out_ready low for cycles 2–6:
  - in_ready must drop after 4 ops are held.
  - out_sum must not change while stalled.
  - Results 2,4,…,16 must appear in order with none lost.
- 3 ops in flight, rst_n pulsed low between edges → out_valid=0 and all out_* = 0 immediately. After release, no stale result ever appears.
- flush asserted with in_valid=1 and 2 ops in flight → in_ready=0 that cycle, out_valid=0 next cycle, and the next accepted op emerges 4 edges after acceptance.
